tuart_tx: RTL and testbench

//  Tiny-UART transmitter for the SUMP link: returns sample data and metadata to the host.

---
 rtl/tuart_tx.sv | 194 +++++++++++++++++++
 tb/tb_tuart_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tuart_tx.sv
// Tiny-UART transmitter: serialises 1..CMD_WORDS words as start/data(LSB first)/stop frames.
// Define TUART_TX_BUF_EN to add a one-entry request buffer so a transfer can be queued while busy.
module tuart_tx #(
    parameter int unsigned WORD_BITS      = 8,
    parameter int unsigned CMD_WORDS      = 4,
    parameter int unsigned CLK_PER_SAMPLE = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_in,
    input  logic [WORD_BITS*CMD_WORDS-1:0]   data_i,
    input  logic [$clog2(CMD_WORDS+1)-1:0]   words_i,
    input  logic                             stb_i,
    output logic                             rdy_o,
    output logic                             done_o,
    output logic                             tx_o
);

    localparam int unsigned PW = WORD_BITS * CMD_WORDS;
    localparam int unsigned CW = $clog2(CMD_WORDS + 1);
    localparam int unsigned TW = $clog2(CLK_PER_SAMPLE);
    localparam int unsigned BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_SAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WORD_BITS - 1);
    localparam logic [CW-1:0] W_MAX  = CW'(CMD_WORDS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        word_q, word_d;
    logic [CW-1:0]        words_q, words_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [PW-1:0]        payload_q, payload_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 bit_end, fin, accept, launch;
    logic [PW-1:0]        src_data;
    logic [CW-1:0]        src_words;

`ifdef TUART_TX_BUF_EN
    logic                 buf_vld_q, buf_vld_d;
    logic [PW-1:0]        buf_data_q, buf_data_d;
    logic [CW-1:0]        buf_words_q, buf_words_d;
`endif

    function automatic logic [CW-1:0] clamp_words(input logic [CW-1:0] w);
        return (w == '0 || w > W_MAX) ? W_MAX : w;
    endfunction

`ifdef TUART_TX_BUF_EN
    assign rdy_o = !buf_vld_q;
`else
    assign rdy_o = (state_q == IDLE);
`endif

    // Decide whether a transfer starts this edge and where its payload comes from.
    always_comb begin
        bit_end   = (timer_q == T_LAST);
        fin       = (state_q == STOP) && bit_end && (CW'(word_q + 1'b1) == words_q);
        accept    = stb_i && rdy_o;
        src_data  = data_i;
        src_words = clamp_words(words_i);
`ifdef TUART_TX_BUF_EN
        buf_vld_d   = buf_vld_q;
        buf_data_d  = buf_data_q;
        buf_words_d = buf_words_q;
        launch      = 1'b0;
        if (fin && buf_vld_q) begin
            launch    = 1'b1;
            src_data  = buf_data_q;
            src_words = buf_words_q;
            buf_vld_d = 1'b0;
        end else if (accept && (state_q == IDLE || fin)) begin
            launch = 1'b1;
        end else if (accept) begin
            buf_vld_d   = 1'b1;
            buf_data_d  = data_i;
            buf_words_d = clamp_words(words_i);
        end
`else
        launch = accept;
`endif
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_d     = bit_q;
        word_d    = word_q;
        words_d   = words_q;
        shift_d   = shift_q;
        payload_d = payload_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == B_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (fin) begin
                        state_d = IDLE;
                        word_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = START;
                        word_d    = word_q + 1'b1;
                        shift_d   = payload_q[WORD_BITS-1:0];
                        payload_d = payload_q >> WORD_BITS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A launch overrides the STOP->IDLE step so back-to-back transfers have no gap.
        if (launch) begin
            state_d   = START;
            timer_d   = '0;
            bit_d     = '0;
            word_d    = '0;
            words_d   = src_words;
            shift_d   = src_data[WORD_BITS-1:0];
            payload_d = src_data >> WORD_BITS;
        end
    end

    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            word_q    <= '0;
            words_q   <= '0;
            shift_q   <= '0;
            payload_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef TUART_TX_BUF_EN
            buf_vld_q   <= 1'b0;
            buf_data_q  <= '0;
            buf_words_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            words_q   <= words_d;
            shift_q   <= shift_d;
            payload_q <= payload_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
`ifdef TUART_TX_BUF_EN
            buf_vld_q   <= buf_vld_d;
            buf_data_q  <= buf_data_d;
            buf_words_q <= buf_words_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_tuart_tx.sv
// Bench for tuart_tx: directed and random requests against a per-cycle waveform model.
// The model schedules whole frames into expected line/done arrays; honours TUART_TX_BUF_EN.
module tb_tuart_tx;

    localparam int WB   = 8;
    localparam int NW   = 4;
    localparam int CPS  = 4;
    localparam int L1   = (WB + 2) * CPS;
    localparam int MAXC = 8192;
`ifdef TUART_TX_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_in = 1'b0;
    logic [31:0]   data_i = '0;
    logic [2:0]    words_i = '0;
    logic          stb_i = 1'b0;
    logic          rdy_o, done_o, tx_o;

    always #5 clk_i = ~clk_i;

    tuart_tx #(
        .WORD_BITS      (WB),
        .CMD_WORDS      (NW),
        .CLK_PER_SAMPLE (CPS)
    ) dut (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .data_i  (data_i),
        .words_i (words_i),
        .stb_i   (stb_i),
        .rdy_o   (rdy_o),
        .done_o  (done_o),
        .tx_o    (tx_o)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit exp_tx[MAXC];
    bit exp_done[MAXC];
    int busy_end    = 0;
    int pend_launch = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_clear(input int from);
        for (int i = from; i < MAXC; i++) begin
            exp_tx[i]   = 1'b1;
            exp_done[i] = 1'b0;
        end
        busy_end    = 0;
        pend_launch = 0;
    endfunction

    // Line picture of a transfer: per word a 0, the data bits LSB first, a 1; each bit CPS cycles.
    function automatic void schedule(input int start, input logic [31:0] d, input int nw);
        logic [31:0] dv;
        bit          bv;
        int          idx;
        dv = d;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < WB + 2; b++) begin
                if (b == 0)           bv = 1'b0;
                else if (b == WB + 1) bv = 1'b1;
                else                  bv = dv[w*WB + b - 1];
                for (int c = 0; c < CPS; c++) begin
                    idx = start + (w * (WB + 2) + b) * CPS + c;
                    if (idx < MAXC) exp_tx[idx] = bv;
                end
            end
        end
        if (start + nw * L1 < MAXC) exp_done[start + nw * L1] = 1'b1;
    endfunction

    // Request sampled at edge p; readiness is judged on period p-1.
    function automatic void model_req(input int p, input logic [31:0] d, input logic [2:0] w);
        int nw;
        int start;
        nw = (w == 0 || w > NW) ? NW : int'(w);
        if (!BUF) begin
            if (p - 1 >= busy_end) begin
                schedule(p, d, nw);
                busy_end = p + nw * L1;
            end
        end else if (p - 1 >= pend_launch) begin
            start = (p > busy_end) ? p : busy_end;
            schedule(start, d, nw);
            if (start > p) pend_launch = start;
            busy_end = start + nw * L1;
        end
    endfunction

    function automatic bit exp_rdy(input int q);
        return BUF ? (q >= pend_launch) : (q >= busy_end);
    endfunction

    task automatic cycle(input bit stb, input logic [31:0] d, input logic [2:0] w);
        stb_i   = stb;
        data_i  = d;
        words_i = w;
        @(posedge clk_i);
        if (stb && rst_in) model_req(cyc + 1, d, w);
        #1;
        cyc++;
        stb_i   = 1'b0;
        data_i  = $urandom;
        words_i = 3'($urandom);
        if (cyc < MAXC) begin
            chk("tx", tx_o, exp_tx[cyc]);
            chk("done", done_o, exp_done[cyc]);
            chk("rdy", rdy_o, exp_rdy(cyc));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 3'($urandom));
    endtask

    initial begin
        model_clear(0);

        // reset held, then released
        idle(3);
        rst_in = 1'b1;
        idle(2);

        // single 0xA5 word with a second request ten cycles in
        cycle(1'b1, 32'h0000_00A5, 3'd1);
        idle(9);
        cycle(1'b1, 32'h0000_003C, 3'd1);
        idle(50);

        // four words back-to-back, then words_i=0 clamp
        cycle(1'b1, 32'h1234_5678, 3'd4);
        idle(170);
        cycle(1'b1, 32'hDEAD_BEEF, 3'd0);
        idle(170);

        // oversize word count clamps too
        cycle(1'b1, 32'hC0FF_EE01, 3'd7);
        idle(170);

        // two requests two cycles apart
        cycle(1'b1, 32'h0000_0055, 3'd1);
        cycle(1'b0, 32'h0, 3'd0);
        cycle(1'b1, 32'h0000_00AA, 3'd1);
        idle(90);

        // asynchronous reset in the middle of a frame
        cycle(1'b1, 32'hF0F0_0F0F, 3'd4);
        idle(22);
        #2;
        rst_in = 1'b0;
        #1;
        chk("rst_async_tx", tx_o, 1'b1);
        chk("rst_async_rdy", rdy_o, 1'b1);
        chk("rst_async_done", done_o, 1'b0);
        model_clear(cyc);
        idle(2);
        rst_in = 1'b1;
        idle(3);

        // random requests, including many while busy
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b1, $urandom, 3'($urandom_range(0, 7)));
            else
                cycle(1'b0, $urandom, 3'($urandom));
        end
        idle(200);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
